// File: rtl/fabric_config_loader.sv
// fabric_config_loader
//   Serializes a host-supplied configuration bitstream into the tile
//   configuration chain, LSB first, one bit per cycle. It then holds the
//   latch strobe for SET_CYCLES cycles and pulses done.
//
// Optional feature macro: FABRIC_CONFIG_LOADER_PARITY_EN
//   When defined, the even parity of the shifted bits is checked against
//   exp_parity, and the result appears on parity_err.
//   When undefined, parity_err is tied low and exp_parity is ignored.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start, bit_count    load request and chain length (sampled together in idle)
//   abort               cancel the load in progress
//   word_data/valid     host word stream; word_ready is the handshake back
//   cfg_cen             shift enable to the chain head
//   cfg_shift_out       serial bit to the chain head
//   cfg_cset            configuration latch strobe
//   busy, done          status; done is a one-cycle completion pulse
//   exp_parity          expected even parity (sampled with start)
//   parity_err          parity mismatch flag
//
// Every output is decoded from registers only.
module fabric_config_loader #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned SET_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  bit_count,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_cen,
    output logic              cfg_shift_out,
    output logic              cfg_cset,
    output logic              busy,
    output logic              done,
    input  logic              exp_parity,
    output logic              parity_err
);

    localparam int unsigned WlW = $clog2(WORD_W + 1);
    localparam int unsigned ScW = (SET_CYCLES > 1) ? $clog2(SET_CYCLES) : 1;

    localparam logic [CNT_W-1:0] WordWCnt  = CNT_W'(WORD_W);
    localparam logic [WlW-1:0]   WordWLeft = WlW'(WORD_W);
    localparam logic [ScW-1:0]   SetLast   = ScW'(SET_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StShift, StSet, StDone} state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [WlW-1:0]    word_left_q, word_left_d;
    logic [ScW-1:0]    set_cnt_q, set_cnt_d;
    logic              zero_done_q, zero_done_d;
    logic              start_accept;

    // Abort outranks start even in idle.
    assign start_accept = (state_q == StIdle) && start && !abort;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        remaining_d = remaining_q;
        word_left_d = word_left_q;
        set_cnt_d   = set_cnt_q;
        zero_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_accept) begin
                    if (bit_count != '0) begin
                        remaining_d = bit_count;
                        state_d     = StLoad;
                    end else begin
                        // Zero-length load completes at once with no chain activity.
                        zero_done_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (word_valid) begin
                    sreg_d      = word_data;
                    word_left_d = (remaining_q >= WordWCnt) ? WordWLeft : WlW'(remaining_q);
                    state_d     = StShift;
                end
            end
            StShift: begin
                sreg_d      = sreg_q >> 1;
                remaining_d = remaining_q - CNT_W'(1);
                word_left_d = word_left_q - WlW'(1);
                // The final chain bit wins over the word boundary.
                // Unused high bits of the last word are dropped.
                if (remaining_q == CNT_W'(1)) begin
                    state_d   = StSet;
                    set_cnt_d = SetLast;
                end else if (word_left_q == WlW'(1)) begin
                    state_d = StLoad;
                end
            end
            StSet: begin
                if (set_cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    set_cnt_d = set_cnt_q - ScW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sreg_q      <= '0;
            remaining_q <= '0;
            word_left_q <= '0;
            set_cnt_q   <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            remaining_q <= remaining_d;
            word_left_q <= word_left_d;
            set_cnt_q   <= set_cnt_d;
            zero_done_q <= zero_done_d;
        end
    end

    assign word_ready    = (state_q == StLoad);
    assign cfg_cen       = (state_q == StShift);
    assign cfg_shift_out = (state_q == StShift) & sreg_q[0];
    assign cfg_cset      = (state_q == StSet);
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone) | zero_done_q;

`ifdef FABRIC_CONFIG_LOADER_PARITY_EN
    logic parity_q, exp_q, parity_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q     <= 1'b0;
            exp_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (start_accept) begin
                parity_q     <= 1'b0;
                exp_q        <= exp_parity;
                parity_err_q <= 1'b0;
            end else if (state_q == StShift) begin
                parity_q <= parity_q ^ sreg_q[0];
            end
            // Update on entry to done, so the flag is valid while done is high.
            if ((state_q == StSet) && (state_d == StDone)) begin
                parity_err_q <= parity_q ^ exp_q;
            end
        end
    end

    assign parity_err = parity_err_q;
`else
    logic unused_exp_parity;
    assign unused_exp_parity = exp_parity;
    assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_fabric_config_loader.sv
// Testbench for fabric_config_loader.
// It records every output, cycle by cycle, for each load. It then compares
// what it sees against expectations built from the word list:
//   - bit order
//   - number of shift cycles
//   - cycle count per word
//   - strobe length
module tb_fabric_config_loader;

    localparam int WORD_W     = 32;
    localparam int CNT_W      = 20;
    localparam int SET_CYCLES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic word_valid = 1'b0;
    logic exp_parity = 1'b0;
    logic [CNT_W-1:0]  bit_count = '0;
    logic [WORD_W-1:0] word_data = '0;
    logic word_ready, cfg_cen, cfg_shift_out, cfg_cset, busy, done, parity_err;

    fabric_config_loader #(
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W),
        .SET_CYCLES(SET_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bit_count    (bit_count),
        .abort        (abort),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .cfg_cen      (cfg_cen),
        .cfg_shift_out(cfg_shift_out),
        .cfg_cset     (cfg_cset),
        .busy         (busy),
        .done         (done),
        .exp_parity   (exp_parity),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [WORD_W-1:0] words[$];
    logic cen_tr[$], so_tr[$], cset_tr[$], done_tr[$], busy_tr[$], ready_tr[$], valid_tr[$],
          perr_tr[$];
    int abort_idx;
    int timed_out;

    int obs_cen, obs_cset, obs_cset_runs, obs_done, obs_done_idx, obs_first_cset, obs_last_cen;
    int obs_runs, obs_max_run, obs_ready, obs_withheld, obs_overlap, obs_busy_cnt;
    logic obs_busy_last, obs_perr_done, obs_perr_last, obs_perr_any;
    logic [127:0] obs_vec;

    // Reference: chain bit i is bit (i mod W) of word (i div W).
    function automatic logic [127:0] model_bits(input int n);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < n && i < 128; i++) v[i] = words[i / WORD_W][i % WORD_W];
        return v;
    endfunction

    // Reference latency, counted from the first cycle after start to done.
    // It is the sum of:
    //   - one ready cycle per word taken
    //   - one cycle per chain bit
    //   - the strobe cycles
    //   - the ready cycles in which no word was offered
    function automatic int model_done_idx(input int n, input int withheld);
        return (n + WORD_W - 1) / WORD_W + n + SET_CYCLES + withheld;
    endfunction

    // Starts a load and feeds words from the words queue, recording the
    // outputs every cycle. Stimulus knobs:
    //   - stall_len withheld ready cycles before word stall_word
    //   - random withholding at drop_pct percent
    //   - abort on the abort_at-th shift cycle
    //   - a stray start (bit_count=100) at trace index xstart_at
    task automatic run_load(input int n, input int stall_word, input int stall_len,
                            input int drop_pct, input int abort_at, input int xstart_at,
                            input logic expp);
        int widx = 0;
        int stall_left = stall_len;
        int cen_seen = 0;
        int tail = -1;
        int c = 0;
        bit stop = 0;
        cen_tr.delete(); so_tr.delete(); cset_tr.delete(); done_tr.delete();
        busy_tr.delete(); ready_tr.delete(); valid_tr.delete(); perr_tr.delete();
        abort_idx = -1;
        timed_out = 0;
        start = 1'b1;
        bit_count = n[CNT_W-1:0];
        exp_parity = expp;
        @(posedge clk); #1;
        start = 1'b0;
        while (!stop) begin
            cen_tr.push_back(cfg_cen);   so_tr.push_back(cfg_shift_out);
            cset_tr.push_back(cfg_cset); done_tr.push_back(done);
            busy_tr.push_back(busy);     ready_tr.push_back(word_ready);
            perr_tr.push_back(parity_err);
            if (cfg_cen === 1'b1) cen_seen++;
            abort = 1'b0;
            start = 1'b0;
            if (abort_at != 0 && cfg_cen === 1'b1 && cen_seen == abort_at && abort_idx < 0) begin
                abort = 1'b1;
                abort_idx = c;
                tail = 6;
            end
            if (c == xstart_at) begin
                start = 1'b1;
                bit_count = CNT_W'(100);
            end
            word_valid = 1'b0;
            if (widx < words.size()) begin
                if (word_ready === 1'b1 && widx == stall_word && stall_left > 0) begin
                    stall_left--;
                end else if (word_ready === 1'b1 && drop_pct != 0 &&
                             $urandom_range(99) < drop_pct) begin
                    word_valid = 1'b0;
                end else begin
                    word_valid = 1'b1;
                    word_data = words[widx];
                    if (word_ready === 1'b1) widx++;
                end
            end
            valid_tr.push_back(word_valid);
            if (tail < 0 && done === 1'b1) tail = 6;
            @(posedge clk); #1;
            c++;
            if (tail == 0) stop = 1;
            else if (tail > 0) tail--;
            if (c >= 3000) begin
                timed_out = 1;
                stop = 1;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        word_valid = 1'b0;
        n_cmp++;
        if (timed_out != 0) begin
            n_fail++;
            $display("FAIL load_bound: got no completion in 3000 cycles want done or idle");
        end
    endtask

    // Reduces the recorded trace to counts and indices.
    task automatic summarize();
        int run = 0;
        obs_cen = 0; obs_cset = 0; obs_cset_runs = 0; obs_done = 0; obs_done_idx = -1;
        obs_first_cset = -1; obs_last_cen = -1; obs_runs = 0; obs_max_run = 0; obs_ready = 0;
        obs_withheld = 0; obs_overlap = 0; obs_busy_cnt = 0; obs_vec = '0; obs_perr_any = 1'b0;
        for (int i = 0; i < cen_tr.size(); i++) begin
            if (cen_tr[i] === 1'b1) begin
                if (obs_cen < 128) obs_vec[obs_cen] = so_tr[i];
                obs_cen++;
                obs_last_cen = i;
                if (i == 0 || cen_tr[i-1] !== 1'b1) begin
                    obs_runs++;
                    run = 0;
                end
                run++;
                if (run > obs_max_run) obs_max_run = run;
            end
            if (cset_tr[i] === 1'b1) begin
                obs_cset++;
                if (obs_first_cset < 0) obs_first_cset = i;
                if (i == 0 || cset_tr[i-1] !== 1'b1) obs_cset_runs++;
            end
            if (done_tr[i] === 1'b1) begin
                obs_done++;
                if (obs_done_idx < 0) obs_done_idx = i;
            end
            if (ready_tr[i] === 1'b1) begin
                obs_ready++;
                if (valid_tr[i] !== 1'b1) obs_withheld++;
            end
            if (busy_tr[i] === 1'b1) obs_busy_cnt++;
            if (perr_tr[i] !== 1'b0) obs_perr_any = 1'b1;
            if ((cen_tr[i] === 1'b1 && (ready_tr[i] !== 1'b0 || cset_tr[i] !== 1'b0)) ||
                (cset_tr[i] === 1'b1 && ready_tr[i] !== 1'b0)) obs_overlap++;
        end
        obs_busy_last = busy_tr[busy_tr.size()-1];
        obs_perr_last = perr_tr[perr_tr.size()-1];
        obs_perr_done = (obs_done_idx >= 0) ? perr_tr[obs_done_idx] : 1'bx;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({word_ready, cfg_cen, cfg_shift_out, cfg_cset, busy, done, parity_err} !== 7'b0)
            begin n_fail++; $display("FAIL reset_outputs: got %b want 0000000",
            {word_ready, cfg_cen, cfg_shift_out, cfg_cset, busy, done, parity_err}); end
        rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; bit_count = CNT_W'(16);
        @(posedge clk); #1;
        start = 1'b0; word_valid = 1'b1; word_data = '1;
        for (int k = 0; k < 10 && cfg_cen !== 1'b1; k++) begin @(posedge clk); #1; end
        n_cmp++; if (cfg_cen !== 1'b1)
            begin n_fail++; $display("FAIL reset_reach_shift: got cen=%b want 1", cfg_cen); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({word_ready, cfg_cen, cfg_shift_out, cfg_cset, busy, done, parity_err} !== 7'b0)
            begin n_fail++; $display("FAIL reset_midload: got %b want 0000000",
            {word_ready, cfg_cen, cfg_shift_out, cfg_cset, busy, done, parity_err}); end
        rst = 1'b0; word_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({busy, cfg_cen, done} !== 3'b0)
            begin n_fail++; $display("FAIL reset_after: got %b want 000", {busy, cfg_cen, done}); end
    endtask

    task automatic test_basic();
        words.delete(); words.push_back(32'h000000A5);
        run_load(8, -1, 0, 0, 0, -1, 1'b0);
        summarize();
        n_cmp++; if (obs_cen !== 8)
            begin n_fail++; $display("FAIL basic_cen: got %0d want 8", obs_cen); end
        n_cmp++; if (obs_vec !== 128'hA5)
            begin n_fail++; $display("FAIL basic_bits: got %h want a5", obs_vec); end
        n_cmp++; if (obs_runs !== 1)
            begin n_fail++; $display("FAIL basic_runs: got %0d want 1", obs_runs); end
        n_cmp++; if (obs_cset !== SET_CYCLES || obs_cset_runs !== 1)
            begin n_fail++; $display("FAIL basic_cset: got %0d in %0d runs want %0d in 1",
            obs_cset, obs_cset_runs, SET_CYCLES); end
        n_cmp++; if (obs_first_cset !== obs_last_cen + 1)
            begin n_fail++; $display("FAIL basic_cset_start: got %0d want %0d",
            obs_first_cset, obs_last_cen + 1); end
        n_cmp++; if (obs_done !== 1 || obs_done_idx !== model_done_idx(8, 0))
            begin n_fail++; $display("FAIL basic_done: got %0d at %0d want 1 at %0d",
            obs_done, obs_done_idx, model_done_idx(8, 0)); end
        n_cmp++; if (obs_busy_last !== 1'b0)
            begin n_fail++; $display("FAIL basic_idle: got busy=%b want 0", obs_busy_last); end
    endtask

    task automatic test_multi_word();
        words.delete(); words.push_back(32'hFFFFFFFF); words.push_back(32'h000000F0);
        run_load(40, -1, 0, 0, 0, -1, 1'b0);
        summarize();
        n_cmp++; if (obs_cen !== 40)
            begin n_fail++; $display("FAIL multi_cen: got %0d want 40", obs_cen); end
        n_cmp++; if (obs_vec !== model_bits(40))
            begin n_fail++; $display("FAIL multi_bits: got %h want %h", obs_vec, model_bits(40)); end
        n_cmp++; if (obs_runs !== 2 || obs_max_run !== 32)
            begin n_fail++; $display("FAIL multi_runs: got %0d runs max %0d want 2 max 32",
            obs_runs, obs_max_run); end
        n_cmp++; if (obs_done_idx !== model_done_idx(40, 0))
            begin n_fail++; $display("FAIL multi_done_idx: got %0d want %0d",
            obs_done_idx, model_done_idx(40, 0)); end
    endtask

    task automatic test_stall();
        words.delete(); words.push_back($urandom); words.push_back($urandom);
        run_load(64, 1, 10, 0, 0, -1, 1'b0);
        summarize();
        n_cmp++; if (obs_withheld !== 10 || obs_ready !== 12)
            begin n_fail++; $display("FAIL stall_ready: got %0d idle of %0d ready want 10 of 12",
            obs_withheld, obs_ready); end
        n_cmp++; if (obs_overlap !== 0)
            begin n_fail++; $display("FAIL stall_overlap: got %0d want 0", obs_overlap); end
        n_cmp++; if (obs_cen !== 64 || obs_vec !== model_bits(64))
            begin n_fail++; $display("FAIL stall_bits: got %0d bits %h want 64 bits %h",
            obs_cen, obs_vec, model_bits(64)); end
        n_cmp++; if (obs_first_cset !== obs_last_cen + 1 || obs_done_idx !== model_done_idx(64, 10))
            begin n_fail++; $display("FAIL stall_timing: got cset %0d done %0d want %0d %0d",
            obs_first_cset, obs_done_idx, obs_last_cen + 1, model_done_idx(64, 10)); end
    endtask

    task automatic test_abort();
        words.delete(); words.push_back($urandom);
        run_load(32, -1, 0, 0, 5, -1, 1'b0);
        summarize();
        n_cmp++; if (obs_cen !== 5 || obs_vec !== model_bits(5))
            begin n_fail++; $display("FAIL abort_bits: got %0d bits %h want 5 bits %h",
            obs_cen, obs_vec, model_bits(5)); end
        n_cmp++; if (abort_idx < 0 || busy_tr[abort_idx+1] !== 1'b0 || cen_tr[abort_idx+1] !== 1'b0)
            begin n_fail++; $display("FAIL abort_next: got abort at %0d not idle next want idle",
            abort_idx); end
        n_cmp++; if (obs_cset !== 0 || obs_done !== 0)
            begin n_fail++; $display("FAIL abort_quiet: got cset %0d done %0d want 0 0",
            obs_cset, obs_done); end
        words.delete(); words.push_back($urandom);
        run_load(32, -1, 0, 0, 0, -1, 1'b0);
        summarize();
        n_cmp++; if (obs_cen !== 32 || obs_vec !== model_bits(32) || obs_done !== 1)
            begin n_fail++; $display("FAIL abort_restart: got %0d bits %h done %0d want 32 %h 1",
            obs_cen, obs_vec, obs_done, model_bits(32)); end
    endtask

    task automatic test_zero_and_busy_start();
        words.delete();
        run_load(0, -1, 0, 0, 0, -1, 1'b0);
        summarize();
        n_cmp++; if (obs_done !== 1 || obs_done_idx !== 0)
            begin n_fail++; $display("FAIL zero_done: got %0d at %0d want 1 at 0",
            obs_done, obs_done_idx); end
        n_cmp++; if (obs_cen !== 0 || obs_busy_cnt !== 0 || obs_cset !== 0)
            begin n_fail++; $display("FAIL zero_quiet: got cen %0d busy %0d cset %0d want 0 0 0",
            obs_cen, obs_busy_cnt, obs_cset); end
        words.delete(); words.push_back($urandom);
        run_load(8, -1, 0, 0, 0, 3, 1'b0);
        summarize();
        n_cmp++; if (obs_cen !== 8 || obs_vec !== model_bits(8))
            begin n_fail++; $display("FAIL busy_start_bits: got %0d bits %h want 8 bits %h",
            obs_cen, obs_vec, model_bits(8)); end
        n_cmp++; if (obs_done_idx !== model_done_idx(8, 0) || obs_busy_last !== 1'b0)
            begin n_fail++; $display("FAIL busy_start_done: got %0d busy %b want %0d busy 0",
            obs_done_idx, obs_busy_last, model_done_idx(8, 0)); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            logic expp;
            n = $urandom_range(100, 1);
            expp = 1'($urandom);
            words.delete();
            for (int w = 0; w < (n + WORD_W - 1) / WORD_W; w++) words.push_back($urandom);
            run_load(n, -1, 0, 30, 0, -1, expp);
            summarize();
            n_cmp++; if (obs_cen !== n || obs_vec !== model_bits(n))
                begin n_fail++; $display("FAIL rand_bits[%0d]: got %0d bits %h want %0d bits %h",
                it, obs_cen, obs_vec, n, model_bits(n)); end
            n_cmp++; if (obs_cset !== SET_CYCLES || obs_first_cset !== obs_last_cen + 1)
                begin n_fail++; $display("FAIL rand_cset[%0d]: got %0d at %0d want %0d at %0d",
                it, obs_cset, obs_first_cset, SET_CYCLES, obs_last_cen + 1); end
            n_cmp++; if (obs_done !== 1 || obs_done_idx !== model_done_idx(n, obs_withheld))
                begin n_fail++; $display("FAIL rand_done[%0d]: got %0d at %0d want 1 at %0d",
                it, obs_done, obs_done_idx, model_done_idx(n, obs_withheld)); end
            n_cmp++; if (obs_overlap !== 0 || obs_busy_last !== 1'b0)
                begin n_fail++; $display("FAIL rand_outputs[%0d]: got overlap %0d busy %b want 0 0",
                it, obs_overlap, obs_busy_last); end
`ifdef FABRIC_CONFIG_LOADER_PARITY_EN
            n_cmp++; if (obs_perr_done !== ((^model_bits(n)) ^ expp))
                begin n_fail++; $display("FAIL rand_parity[%0d]: got %b want %b",
                it, obs_perr_done, (^model_bits(n)) ^ expp); end
`else
            n_cmp++; if (obs_perr_any !== 1'b0)
                begin n_fail++; $display("FAIL rand_parity_tied[%0d]: got %b want 0",
                it, obs_perr_any); end
`endif
        end
    endtask

    task automatic test_parity();
        words.delete(); words.push_back(32'h000000A5);
`ifdef FABRIC_CONFIG_LOADER_PARITY_EN
        run_load(8, -1, 0, 0, 0, -1, 1'b0);
        summarize();
        n_cmp++; if (obs_perr_done !== 1'b0)
            begin n_fail++; $display("FAIL parity_match: got %b want 0", obs_perr_done); end
        run_load(8, -1, 0, 0, 0, -1, 1'b1);
        summarize();
        n_cmp++; if (obs_perr_done !== 1'b1 || obs_perr_last !== 1'b1)
            begin n_fail++; $display("FAIL parity_err: got %b then %b want 1 then 1",
            obs_perr_done, obs_perr_last); end
        words.delete();
        run_load(0, -1, 0, 0, 0, -1, 1'b0);
        n_cmp++; if (perr_tr[0] !== 1'b0)
            begin n_fail++; $display("FAIL parity_clear: got %b want 0", perr_tr[0]); end
`else
        run_load(8, -1, 0, 0, 0, -1, 1'b1);
        summarize();
        n_cmp++; if (obs_perr_any !== 1'b0)
            begin n_fail++; $display("FAIL parity_tied: got %b want 0", obs_perr_any); end
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_multi_word();
        test_stall();
        test_abort();
        test_zero_and_busy_start();
        test_random();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by 1000000 want finish");
        $fatal(1);
    end

endmodule
